// File: rtl/tomasulo_dbg_pkg.sv
// Shared debug-dump definitions for the Tomasulo core's register dump path.
// Holds the dump FSM state type, default widths and the stream word layout, so that the
// dump engine and a host-side logger agree on one format.
package tomasulo_dbg_pkg;

  localparam int unsigned DefNumRegs = 32;
  localparam int unsigned DefAddrW   = 5;
  localparam int unsigned DefDataW   = 32;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StSetup,
    StEmit,
    StFin
  } dump_state_t;

  // One word on the dump stream, at the default widths.
  typedef struct packed {
    logic [DefAddrW-1:0] idx;
    logic [DefDataW-1:0] data;
    logic                last;
  } dump_word_t;

endpackage

// File: rtl/reg_dump_engine.sv
// reg_dump_engine: once the core reports done, sweeps the architectural register file through
// the core's debug read port and streams (index, data) words to a host, keeping a running
// wrap-around checksum of the words the host accepted.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             request a dump; only acted on when idle or finished
//   core_done         core completion flag; gates the start of the sweep
//   reg_addr/reg_data debug read port (data valid READ_LAT cycles after an address change)
//   out_valid/ready   stream handshake; out_idx, out_data, out_last form the word
//   dump_done         level, high once the whole register file has been accepted
//   checksum          sum of accepted out_data, modulo 2**DATA_W
module reg_dump_engine
  import tomasulo_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              core_done,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              dump_done,
  output logic [DATA_W-1:0] checksum
);

  // Wide enough to hold READ_LAT, and at least one bit when READ_LAT is 0.
  localparam int unsigned      CntW    = $clog2(READ_LAT + 2);
  localparam logic [CntW-1:0]  CntLast = CntW'(READ_LAT);
  localparam logic [ADDR_W-1:0] IdxLast = ADDR_W'(NUM_REGS - 1);

  dump_state_t     state;
  logic [CntW-1:0] wait_cnt;

  // reg_addr is the sweep index itself: the read port always sees the index being fetched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      wait_cnt  <= '0;
      reg_addr  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      dump_done <= 1'b0;
      checksum  <= '0;
    end else begin
      unique case (state)
        StIdle, StFin: begin
          if (start) begin
            state     <= StArm;
            reg_addr  <= '0;
            checksum  <= '0;
            dump_done <= 1'b0;
          end
        end
        StArm: begin
          // Only the first sampled core_done matters; later drops are ignored.
          if (core_done) begin
            state    <= StSetup;
            wait_cnt <= '0;
          end
        end
        StSetup: begin
          // READ_LAT+1 cycles here so the last cycle sees settled read data.
          if (wait_cnt == CntLast) begin
            out_data  <= reg_data;
            out_idx   <= reg_addr;
            out_last  <= (reg_addr == IdxLast);
            out_valid <= 1'b1;
            state     <= StEmit;
          end else begin
            wait_cnt <= wait_cnt + CntW'(1);
          end
        end
        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            checksum  <= checksum + out_data;
            if (reg_addr == IdxLast) begin
              state     <= StFin;
              dump_done <= 1'b1;
            end else begin
              reg_addr <= reg_addr + ADDR_W'(1);
              wait_cnt <= '0;
              state    <= StSetup;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_engine.sv
// Bench for reg_dump_engine: two instances (READ_LAT 1 and 2) share the control inputs, each
// with its own register-read model. A transaction-level model predicts the stream contents,
// checksum, dump_done and when out_valid may be high; directed phases add literal checks.
module tb_reg_dump_engine;

  localparam int N    = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 2;

  logic clk = 1'b0;
  logic reset, start, core_done, out_ready;

  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];
  logic          ov [2];
  logic [AW-1:0] oi [2];
  logic [DW-1:0] od [2];
  logic          ol [2];
  logic          dd [2];
  logic [DW-1:0] cs [2];

  logic [DW-1:0] regs [N];
  int            age  [2];
  logic [AW-1:0] last_ra [2];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model state per instance: phase 0 idle, 1 dumping, 2 finished.
  int            m_phase [2];
  int            m_idx   [2];
  logic [DW-1:0] m_sum   [2];
  bit            m_go    [2];
  int            m_vld   [2];
  int            n_words [2];
  int            n_last  [2];

  int se, ge, l0, l1;
  logic [DW-1:0] exp_rand;

  reg_dump_engine #(
    .NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .core_done(core_done),
    .reg_addr(ra[0]), .reg_data(rd[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_idx(oi[0]), .out_data(od[0]), .out_last(ol[0]), .dump_done(dd[0]),
    .checksum(cs[0])
  );

  reg_dump_engine #(
    .NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .core_done(core_done),
    .reg_addr(ra[1]), .reg_data(rd[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_idx(oi[1]), .out_data(od[1]), .out_last(ol[1]), .dump_done(dd[1]),
    .checksum(cs[1])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read data is only trustworthy once the address has been stable for READ_LAT edges;
  // before that a poison value stands in for X.
  assign rd[0] = (age[0] >= LAT0) ? regs[ra[0]] : (32'hDEAD_0000 | 32'(ra[0]));
  assign rd[1] = (age[1] >= LAT1) ? regs[ra[1]] : (32'hDEAD_0000 | 32'(ra[1]));

  initial begin
    age[0] = 15; age[1] = 15;
    last_ra[0] = '0; last_ra[1] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (ra[k] !== last_ra[k]) age[k] = 0;
        else if (age[k] < 15) age[k] = age[k] + 1;
        last_ra[k] = ra[k];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at each falling edge: compare, then advance the model to what the next rising
  // edge will do given the inputs currently applied.
  task automatic model_step(input int k);
    int  l;
    int  ph;
    bit  exp_valid;
    l = (k == 0) ? LAT0 : LAT1;
    if (reset) begin
      chk($sformatf("rst_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_idx%0d", k), oi[k], 0);
      chk($sformatf("rst_data%0d", k), od[k], 0);
      chk($sformatf("rst_last%0d", k), ol[k], 0);
      chk($sformatf("rst_done%0d", k), dd[k], 0);
      chk($sformatf("rst_sum%0d", k), cs[k], 0);
      chk($sformatf("rst_addr%0d", k), ra[k], 0);
      m_phase[k] = 0; m_idx[k] = 0; m_sum[k] = '0; m_go[k] = 0;
      return;
    end
    ph        = m_phase[k];
    exp_valid = (ph == 1) && m_go[k] && (cyc >= m_vld[k]);
    chk($sformatf("valid%0d", k), ov[k], exp_valid);
    chk($sformatf("dump_done%0d", k), dd[k], ph == 2);
    chk($sformatf("checksum%0d", k), cs[k], m_sum[k]);
    if (ph == 1) chk($sformatf("reg_addr%0d", k), ra[k], m_idx[k]);
    if (exp_valid) begin
      chk($sformatf("idx%0d", k), oi[k], m_idx[k]);
      chk($sformatf("data%0d", k), od[k], regs[m_idx[k]]);
      chk($sformatf("last%0d", k), ol[k], m_idx[k] == N - 1);
    end
    // First sampled core_done while armed: data shows up READ_LAT+1 edges later.
    if (ph == 1 && !m_go[k] && core_done) begin
      m_go[k]  = 1;
      m_vld[k] = cyc + 2 + l;
    end
    if (exp_valid && out_ready) begin
      m_sum[k] = m_sum[k] + regs[m_idx[k]];
      n_words[k]++;
      if (ol[k]) n_last[k]++;
      if (m_idx[k] == N - 1) begin
        m_phase[k] = 2;
      end else begin
        m_idx[k] = m_idx[k] + 1;
        m_vld[k] = cyc + 2 + l;
      end
    end
    if (start && ph != 1) begin
      m_phase[k] = 1; m_idx[k] = 0; m_sum[k] = '0; m_go[k] = 0;
      n_words[k] = 0; n_last[k] = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step(0);
      model_step(1);
    end
  end

  // Pulse start for one cycle; returns the number of the edge that sampled it.
  task automatic pulse_start(output int edge_no);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edge_no = cyc;
  endtask

  task automatic run_until_done(input int base, output int d0, output int d1);
    d0 = -1; d1 = -1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (dd[0] && d0 < 0) d0 = cyc - base;
      if (dd[1] && d1 < 0) d1 = cyc - base;
      if (d0 >= 0 && d1 >= 0) return;
    end
    chk("timeout_done", 0, 1);
  endtask

  task automatic wait_word(input int k, input int idx, input string name);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ov[k] && oi[k] == AW'(idx)) return;
    end
    chk(name, 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; core_done = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) regs[i] = 32'h100 + 32'(i);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", ov[0], 0);
    chk("idle_done", dd[0], 0);
    chk("idle_sum", cs[0], 0);

    // Basic dump, core already done, sink always ready.
    core_done = 1'b1;
    pulse_start(se);
    while (cyc < se + 8) begin
      @(negedge clk);
      if (cyc == se + 2) chk("t1_pre_valid", ov[0], 0);
      if (cyc == se + 3) begin
        chk("t1_first_valid", ov[0], 1);
        chk("t1_first_data", od[0], 32'h100);
      end
      if (cyc == se + 4) chk("t1_first_valid_lat2", ov[1], 1);
      if (cyc == se + 5) chk("t1_gap", ov[0], 0);
      if (cyc == se + 6) chk("t1_second_data", od[0], 32'h101);
      if (cyc == se + 8) chk("t1_second_idx_lat2", oi[1], 1);
    end
    run_until_done(se, l0, l1);
    chk("t1_done_cycles", l0, 97);
    chk("t1_done_cycles_lat2", l1, 129);
    chk("t1_checksum", cs[0], 32'h21F0);
    chk("t1_checksum_lat2", cs[1], 32'h21F0);
    chk("t1_words", n_words[0], 32);
    chk("t1_last_count", n_last[0], 1);

    // Gating on core_done, then backpressure on idx 5.
    core_done = 1'b0;
    pulse_start(se);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("gate_addr", ra[0], 0);
      chk("gate_valid", ov[0], 0);
    end
    @(posedge clk);
    #1 core_done = 1'b1;
    ge = cyc + 1;
    while (cyc < ge + 3) begin
      @(negedge clk);
      if (cyc == ge + 1) chk("gate_pre_valid", ov[0], 0);
      if (cyc == ge + 2) begin
        chk("gate_first_valid", ov[0], 1);
        chk("gate_first_idx", oi[0], 0);
        chk("gate_pre_valid_lat2", ov[1], 0);
      end
      if (cyc == ge + 3) chk("gate_first_valid_lat2", ov[1], 1);
    end
    wait_word(0, 4, "bp_wait_idx4");
    @(posedge clk);
    #1 out_ready = 1'b0;
    wait_word(0, 5, "bp_wait_idx5");
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      chk("bp_valid", ov[0], 1);
      chk("bp_idx", oi[0], 5);
      chk("bp_data", od[0], 32'h105);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    run_until_done(se, l0, l1);
    chk("bp_checksum", cs[0], 32'h21F0);
    chk("bp_checksum_lat2", cs[1], 32'h21F0);
    chk("bp_words", n_words[0], 32);

    // Reset in the middle of a dump.
    pulse_start(se);
    wait_word(0, 10, "rst_wait_idx10");
    #2 reset = 1'b1;
    #1;
    chk("async_valid", ov[0], 0);
    chk("async_idx", oi[0], 0);
    chk("async_data", od[0], 0);
    chk("async_sum", cs[0], 0);
    chk("async_addr", ra[0], 0);
    chk("async_valid_lat2", ov[1], 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    pulse_start(se);
    while (cyc < se + 3) @(negedge clk);
    chk("rst_restart_idx", oi[0], 0);
    chk("rst_restart_data", od[0], 32'h100);
    run_until_done(se, l0, l1);
    chk("rst_checksum", cs[0], 32'h21F0);
    chk("rst_checksum_lat2", cs[1], 32'h21F0);

    // Restart from FIN with new contents; extra starts mid-dump must be ignored.
    for (int i = 0; i < N; i++) regs[i] = 32'(i);
    pulse_start(se);
    @(negedge clk);
    chk("fin_restart_done", dd[0], 0);
    chk("fin_restart_sum", cs[0], 0);
    for (int j = 0; j < 4; j++) begin
      int gap;
      int dummy;
      gap = $urandom_range(5, 15);
      repeat (gap) @(posedge clk);
      pulse_start(dummy);
    end
    run_until_done(se, l0, l1);
    chk("fin_done_cycles", l0, 97);
    chk("fin_done_cycles_lat2", l1, 129);
    chk("fin_checksum", cs[0], 32'h1F0);
    chk("fin_checksum_lat2", cs[1], 32'h1F0);

    // Random contents, random sink stalls, core_done toggling.
    for (int r = 0; r < 3; r++) begin
      bit finished;
      exp_rand = '0;
      for (int i = 0; i < N; i++) begin
        regs[i]  = $urandom;
        exp_rand = exp_rand + regs[i];
      end
      core_done = 1'b0;
      pulse_start(se);
      finished = 0;
      for (int c = 0; c < 2000 && !finished; c++) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
        core_done = ($urandom_range(0, 3) == 0);
        finished  = dd[0] && dd[1];
      end
      if (!finished) chk("rand_timeout", 0, 1);
      chk("rand_checksum", cs[0], exp_rand);
      chk("rand_checksum_lat2", cs[1], exp_rand);
      chk("rand_words", n_words[0], 32);
      chk("rand_words_lat2", n_words[1], 32);
    end
    out_ready = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
